// File: rtl/f_le_arbiter_pkg.sv
// Shared float types and arbiter state encoding for the f_less_or_equal sharing logic.
package f_le_arbiter_pkg;

    localparam int unsigned FLEN = 64;

    typedef logic [FLEN-1:0] float_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RSP  = 2'd2
    } arb_state_t;

    // Index width for an N-entry requester set; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/f_le_arbiter_rr_pick.sv
// Combinational round-robin picker with a force-owner override used while a lock is held.
module f_le_arbiter_rr_pick
    import f_le_arbiter_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          force_en_i,
    input  logic [IW-1:0] force_idx_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          gnt_valid_o
);

    always_comb begin
        int unsigned cand;
        cand        = 0;
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        if (force_en_i) begin
            if (req_i[force_idx_i]) begin
                gnt_o[force_idx_i] = 1'b1;
                gnt_idx_o          = force_idx_i;
                gnt_valid_o        = 1'b1;
            end
        end else begin
            // First requester at or after the pointer, wrapping modulo N.
            for (int unsigned k = 0; k < N; k++) begin
                cand = (32'(ptr_i) + k) % N;
                if (!gnt_valid_o && req_i[IW'(cand)]) begin
                    gnt_o[IW'(cand)] = 1'b1;
                    gnt_idx_o        = IW'(cand);
                    gnt_valid_o      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/f_le_arbiter.sv
// Shares one combinational f_less_or_equal comparator between N_REQ requesters with round-robin and lock.
module f_le_arbiter
    import f_le_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_lock,
    input  logic [N_REQ-1:0][FLEN-1:0]  req_a,
    input  logic [N_REQ-1:0][FLEN-1:0]  req_b,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic                        rsp_res,
    output logic                        rsp_err,
    output logic                        busy,
    output float_t                      f_le_a,
    output float_t                      f_le_b,
    input  logic                        f_le_res,
    input  logic                        f_le_err
);

    localparam int unsigned IW = idx_w(N_REQ);

    arb_state_t       state_q, state_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    lock_owner_q, lock_owner_d;
    logic             lock_q, lock_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic             rsp_res_q, rsp_res_d;
    logic             rsp_err_q, rsp_err_d;
    logic             busy_q, busy_d;
    float_t           a_q, a_d;
    float_t           b_q, b_d;

    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]    gnt_idx;
    logic             gnt_valid;
    logic             accept_c;

    f_le_arbiter_rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .force_en_i  (lock_q),
        .force_idx_i (lock_owner_q),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    // One op in flight: a new compare may start in IDLE or alongside the response.
    assign accept_c  = (state_q != CMP) && gnt_valid;
    assign req_ready = accept_c ? gnt : '0;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        lock_owner_d = lock_owner_q;
        lock_d       = lock_q;
        rsp_valid_d  = '0;
        rsp_res_d    = rsp_res_q;
        rsp_err_d    = rsp_err_q;
        a_d          = a_q;
        b_d          = b_q;

        unique case (state_q)
            CMP: begin
                rsp_res_d   = f_le_res;
                rsp_err_d   = f_le_err;
                rsp_valid_d = N_REQ'(1) << owner_q;
                state_d     = RSP;
            end
            default: state_d = IDLE;
        endcase

        if (accept_c) begin
            a_d     = req_a[gnt_idx];
            b_d     = req_b[gnt_idx];
            owner_d = gnt_idx;
            state_d = CMP;
            // A locked sequence counts as a single round-robin turn.
            if (req_lock[gnt_idx]) begin
                lock_d       = 1'b1;
                lock_owner_d = gnt_idx;
            end else begin
                lock_d   = 1'b0;
                rr_ptr_d = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
            end
        end

        busy_d = (state_d != IDLE) || lock_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            lock_owner_q <= '0;
            lock_q       <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_res_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            lock_owner_q <= lock_owner_d;
            lock_q       <= lock_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_res_q    <= rsp_res_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
            a_q          <= a_d;
            b_q          <= b_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign f_le_a    = a_q;
    assign f_le_b    = b_q;

endmodule
